arqt_led_fader: RTL and testbench
=================================

Name: arqt_led_fader

Overview:
- Sits directly downstream of the 4-bit LED PIO and consumes its out_port as per-LED on/off requests.
- Drives the physical LED pins with PWM.
- Ramps each LED's brightness up or down at a fixed rate toward the requested state instead of switching hard.
- Provides a bypass mode and a busy flag for firmware/debug.

Parameters:
N_LEDS, 4, number of LED channels (matches PIO width)
PWM_BITS, 8, width of PWM counter and brightness levels; LVL_MAX = 2^PWM_BITS-1
CLK_DIV, 50, clk cycles per PWM counter increment (>=1)
RAMP_STEP, 8, brightness change per PWM period (1..LVL_MAX)

Ports:
clk  in  1  system clock, all logic rising-edge
reset_n  in  1  synchronous, active-low reset
led_req  in  N_LEDS  per-LED request from PIO out_port; 1=on, 0=off
bypass  in  1  1 = LEDs follow led_req directly, no PWM/ramp
led_out  out  N_LEDS  LED pin drive, registered
busy  out  1  1 while any channel level differs from its target
level  out  N_LEDS*PWM_BITS  current brightness per channel; LED i at [i*PWM_BITS +: PWM_BITS]

Behaviour:
- Reset (sync, reset_n=0 at a clk edge) clears every register: prescaler, pwm_cnt, req_q, all levels, led_out, busy. Outputs stay 0 until first edge with reset_n=1. Reset mid-ramp discards the ramp.
- Input stage: led_req and bypass are registered once (req_q, byp_q). All downstream logic uses the registered copies.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick=1 for one cycle when count==CLK_DIV-1. With CLK_DIV=1, tick is 1 every cycle.
- PWM counter: pwm_cnt, PWM_BITS wide, increments on tick, wraps LVL_MAX->0.
- period_end = tick && pwm_cnt==LVL_MAX. One PWM period = CLK_DIV*2^PWM_BITS cycles.
- Ramp, per channel, evaluated only on period_end and with byp_q=0:
  - req_q[i]=1: level = min(LVL_MAX, level+RAMP_STEP). Saturating; compute in PWM_BITS+1 bits, no wrap.
  - req_q[i]=0: level = max(0, level-RAMP_STEP). Saturating, no underflow.
  - A request flip mid-ramp reverses direction from the current level at the next period_end.
- Bypass (byp_q=1):
  - Every cycle, level[i] snaps to LVL_MAX if req_q[i] else 0.
  - led_out[i] <= req_q[i]. Latency is 2 clk from led_req to led_out.
  - Prescaler and pwm_cnt keep running.
  - Deasserting bypass resumes ramping from the snapped levels.
- PWM compare (byp_q=0), registered:
  - led_out[i] <= (level[i]==LVL_MAX) ? 1 : (pwm_cnt < level[i]).
  - level 0 gives constant 0; LVL_MAX gives constant 1 with no glitch at wrap.
- busy <= 1 if any channel has level[i] != (req_q[i] ? LVL_MAX : 0), else 0. Registered, 1 cycle after the condition.
- led_req change while busy needs no special handling; targets are recomputed every cycle.

Test Plan:
Bench config for all scenarios: CLK_DIV=2, PWM_BITS=4 (LVL_MAX=15), RAMP_STEP=5, so one PWM period = 32 cycles.
- Reset: hold reset_n=0 for 3 edges with led_req=4'hF, bypass=1 -> led_out=0, busy=0, level=0 throughout. First led_out change is no earlier than 2 edges after release.
- Ramp up: led_req 0->4'b0001 -> busy=1 within 2 cycles. LED0 level goes 5, 10, 15 at successive period_ends, then holds at 15. busy=0 one cycle after level=15. led_out[0] is high 5/16 and 10/16 of pwm_cnt values in the first two periods, then constant 1.
- Saturation: RAMP_STEP=7, ramp up and then down -> levels 7, 14, 15 then 8, 1, 0. No wrap past 15 or below 0.
- Reversal: led_req[1]=1 until level=10, then 0 -> next period_end gives level 5, then 0. busy drops after 0.
- Bypass: bypass=1 with led_req=4'b1010 -> led_out=4'b1010 exactly 2 cycles later. levels = {15,0,15,0} on LEDs 3..0, busy=0. Release bypass and set led_req=0 -> levels 10, 5, 0 on LEDs 3 and 1.
- Independence: led_req=4'b0101 ramping up, then flip to 4'b1010 mid-ramp -> LEDs 0/2 ramp down and LEDs 1/3 ramp up simultaneously on the same period_end.

Source files
------------

// File: rtl/arqt_led_fader.sv
// PWM LED fader: takes per-LED on/off requests and ramps each LED's brightness
// toward full or off at a fixed rate, with a direct-drive bypass and a busy flag.
module arqt_led_fader #(
    parameter int N_LEDS    = 4,
    parameter int PWM_BITS  = 8,
    parameter int CLK_DIV   = 50,
    parameter int RAMP_STEP = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_LEDS-1:0]            led_req,
    input  logic                         bypass,
    output logic [N_LEDS-1:0]            led_out,
    output logic                         busy,
    output logic [N_LEDS*PWM_BITS-1:0]   level
);

    localparam int                  DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(RAMP_STEP);

    logic [N_LEDS-1:0]   req_q_reg;
    logic                byp_q_reg;
    logic [DIV_W-1:0]    presc_reg;
    logic [DIV_W-1:0]    presc_next;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [PWM_BITS-1:0] pwm_cnt_next;
    logic                tick;
    logic                period_end;
    logic [N_LEDS-1:0]   led_out_reg;
    logic [N_LEDS-1:0]   led_out_next;
    logic [N_LEDS-1:0]   mismatch;
    logic                busy_reg;

    // Timebase: prescaler sets the PWM step rate, period_end marks the PWM wrap.
    always_comb begin
        tick         = (presc_reg == DIV_LAST);
        presc_next   = tick ? '0 : presc_reg + 1'b1;
        pwm_cnt_next = tick ? pwm_cnt_reg + 1'b1 : pwm_cnt_reg;
        period_end   = tick && (pwm_cnt_reg == LVL_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q_reg   <= '0;
            byp_q_reg   <= 1'b0;
            presc_reg   <= '0;
            pwm_cnt_reg <= '0;
            led_out_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            req_q_reg   <= led_req;
            byp_q_reg   <= bypass;
            presc_reg   <= presc_next;
            pwm_cnt_reg <= pwm_cnt_next;
            led_out_reg <= led_out_next;
            busy_reg    <= |mismatch;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LEDS; gi++) begin : g_chan
            logic [PWM_BITS-1:0] level_reg;
            logic [PWM_BITS-1:0] level_next;
            logic [PWM_BITS-1:0] target;
            logic [PWM_BITS:0]   sum_up;

            // Ramp arithmetic runs one bit wider so the step can saturate instead of wrapping.
            always_comb begin
                target     = req_q_reg[gi] ? LVL_MAX : '0;
                sum_up     = {1'b0, level_reg} + STEP_W;
                level_next = level_reg;
                if (byp_q_reg) begin
                    level_next = target;
                end else if (period_end) begin
                    if (req_q_reg[gi]) begin
                        level_next = (sum_up > {1'b0, LVL_MAX}) ? LVL_MAX : sum_up[PWM_BITS-1:0];
                    end else begin
                        level_next = ({1'b0, level_reg} < STEP_W) ? '0
                                   : level_reg - STEP_W[PWM_BITS-1:0];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    level_reg <= '0;
                end else begin
                    level_reg <= level_next;
                end
            end

            // Full level is forced high so the LED never blinks off at the counter wrap.
            assign led_out_next[gi] = byp_q_reg ? req_q_reg[gi]
                                    : ((level_reg == LVL_MAX) || (pwm_cnt_reg < level_reg));
            assign mismatch[gi]     = (level_reg != target);
            assign level[gi*PWM_BITS +: PWM_BITS] = level_reg;
        end
    endgenerate

    assign led_out = led_out_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_arqt_led_fader.sv
// Bench for arqt_led_fader: two instances (ramp steps 5 and 7) checked every cycle
// against a time-indexed reference model, plus directed ramp/bypass/reversal checks.
module tb_arqt_led_fader;

    localparam int CD  = 2;
    localparam int LM  = 15;
    localparam int PER = CD * 16;

    logic        clk;
    logic        reset_n;
    logic [3:0]  led_req;
    logic        bypass;
    logic [3:0]  led_out_a, led_out_b;
    logic        busy_a, busy_b;
    logic [15:0] level_a, level_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: register contents after the latest clock edge.
    int         m_t;
    logic [3:0] m_rq;
    logic       m_bq;
    int         m_lvl [2][4];
    logic [3:0] m_lo [2];
    logic       m_bz [2];
    int         m_step [2] = '{5, 7};

    int seen_a[$];
    int seen_b[$];
    int seen_c[$];

    arqt_led_fader #(.N_LEDS(4), .PWM_BITS(4), .CLK_DIV(CD), .RAMP_STEP(5)) dut_a (
        .clk(clk), .reset_n(reset_n), .led_req(led_req), .bypass(bypass),
        .led_out(led_out_a), .busy(busy_a), .level(level_a)
    );

    arqt_led_fader #(.N_LEDS(4), .PWM_BITS(4), .CLK_DIV(CD), .RAMP_STEP(7)) dut_b (
        .clk(clk), .reset_n(reset_n), .led_req(led_req), .bypass(bypass),
        .led_out(led_out_b), .busy(busy_b), .level(level_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model across the coming edge using the inputs now applied.
    task automatic model_next();
        int  pwm;
        bit  pe;
        bit  bz;
        int  tgt;
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 4; i++) m_lvl[d][i] = 0;
                m_lo[d] = '0;
                m_bz[d] = 1'b0;
            end
            m_rq = '0;
            m_bq = 1'b0;
            m_t  = 0;
        end else begin
            pwm = (m_t / CD) % 16;
            pe  = ((m_t % PER) == PER - 1);
            for (int d = 0; d < 2; d++) begin
                bz = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    tgt = m_rq[i] ? LM : 0;
                    m_lo[d][i] = m_bq ? m_rq[i] : ((m_lvl[d][i] == LM) || (pwm < m_lvl[d][i]));
                    if (m_lvl[d][i] != tgt) bz = 1'b1;
                    if (m_bq) m_lvl[d][i] = tgt;
                    else if (pe) begin
                        if (m_rq[i]) m_lvl[d][i] = (m_lvl[d][i] + m_step[d] > LM) ? LM : m_lvl[d][i] + m_step[d];
                        else         m_lvl[d][i] = (m_lvl[d][i] - m_step[d] < 0) ? 0 : m_lvl[d][i] - m_step[d];
                    end
                end
                m_bz[d] = bz;
            end
            m_rq = led_req;
            m_bq = bypass;
            m_t++;
        end
    endtask

    task automatic check_all();
        logic [15:0] ev;
        for (int d = 0; d < 2; d++) begin
            ev = '0;
            for (int i = 0; i < 4; i++) ev[i*4 +: 4] = 4'(m_lvl[d][i]);
            if (d == 0) begin
                check_val("led_out_a", 32'(led_out_a), 32'(m_lo[0]));
                check_val("busy_a",    32'(busy_a),    32'(m_bz[0]));
                check_val("level_a",   32'(level_a),   32'(ev));
            end else begin
                check_val("led_out_b", 32'(led_out_b), 32'(m_lo[1]));
                check_val("busy_b",    32'(busy_b),    32'(m_bz[1]));
                check_val("level_b",   32'(level_b),   32'(ev));
            end
        end
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        led_req = '0;
        bypass  = 1'b0;
        step();
    endtask

    // Run n cycles, recording each new level of A[ch], B[ch] and A[ch2].
    task automatic watch(input int n, input int ch, input int ch2);
        int la, lb, lc, va, vb, vc;
        seen_a.delete();
        seen_b.delete();
        seen_c.delete();
        la = 32'(level_a[ch*4 +: 4]);
        lb = 32'(level_b[ch*4 +: 4]);
        lc = 32'(level_a[ch2*4 +: 4]);
        repeat (n) begin
            step();
            va = 32'(level_a[ch*4 +: 4]);
            vb = 32'(level_b[ch*4 +: 4]);
            vc = 32'(level_a[ch2*4 +: 4]);
            if (va != la) begin seen_a.push_back(va); la = va; end
            if (vb != lb) begin seen_b.push_back(vb); lb = vb; end
            if (vc != lc) begin seen_c.push_back(vc); lc = vc; end
        end
    endtask

    task automatic check_seq(input string tag, input int q[$], input int n,
                             input int e0, input int e1, input int e2);
        int got;
        int exp;
        check_val({tag, "_len"}, 32'(q.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            got = (k < q.size()) ? q[k] : -1;
            exp = (k == 0) ? e0 : (k == 1) ? e1 : e2;
            check_val($sformatf("%s_%0d", tag, k), 32'(got), 32'(exp));
        end
    endtask

    initial begin
        int  found;
        logic [15:0] prev;

        // Reset held with requests and bypass asserted.
        reset_n = 1'b0;
        led_req = 4'hF;
        bypass  = 1'b1;
        repeat (3) begin
            step();
            check_val("rst_level", 32'(level_a), 32'h0);
            check_val("rst_out",   32'(led_out_a), 32'h0);
            check_val("rst_busy",  32'(busy_a), 32'h0);
        end
        reset_n = 1'b1;
        step();
        check_val("rst_rel_edge1", 32'(led_out_a), 32'h0);
        step();
        check_val("rst_rel_edge2", 32'(led_out_a), 32'hF);

        // Ramp up then down: step 5 on A, saturating step 7 on B.
        do_reset();
        led_req = 4'b0001;
        step();
        step();
        check_val("ramp_busy", 32'(busy_a), 32'h1);
        watch(4 * PER, 0, 0);
        check_seq("ramp_up_a", seen_a, 3, 5, 10, 15);
        check_seq("sat_up_b",  seen_b, 3, 7, 14, 15);
        check_val("ramp_idle", 32'(busy_a), 32'h0);
        led_req = 4'b0000;
        watch(4 * PER, 0, 0);
        check_seq("ramp_dn_a", seen_a, 3, 10, 5, 0);
        check_seq("sat_dn_b",  seen_b, 3, 8, 1, 0);

        // Reversal on LED1 once it reaches 10.
        do_reset();
        led_req = 4'b0010;
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            step();
            if (level_a[7:4] == 4'd10) found = 1;
        end
        check_val("rev_reach10", 32'(found), 32'h1);
        led_req = 4'b0000;
        watch(3 * PER, 1, 1);
        check_seq("rev_a", seen_a, 2, 5, 0, 0);
        check_val("rev_idle", 32'(busy_a), 32'h0);

        // Bypass latency, snapped levels, then ramp down from the snap.
        do_reset();
        led_req = 4'b1010;
        bypass  = 1'b1;
        step();
        check_val("byp_lat1", 32'(led_out_a), 32'h0);
        step();
        check_val("byp_lat2", 32'(led_out_a), 32'hA);
        step();
        step();
        check_val("byp_level", 32'(level_a), 32'hF0F0);
        check_val("byp_busy",  32'(busy_a), 32'h0);
        bypass  = 1'b0;
        led_req = 4'b0000;
        watch(4 * PER, 3, 1);
        check_seq("byp_rel_l3", seen_a, 3, 10, 5, 0);
        check_seq("byp_rel_l1", seen_c, 3, 10, 5, 0);

        // Independent channels reversing on the same period end.
        do_reset();
        led_req = 4'b0101;
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            step();
            if (level_a[3:0] == 4'd5) found = 1;
        end
        check_val("ind_reach5", 32'(found), 32'h1);
        led_req = 4'b1010;
        prev  = level_a;
        found = 0;
        for (int k = 0; k < 3 * PER && found == 0; k++) begin
            step();
            if (level_a != prev) found = 1;
        end
        check_val("ind_change", 32'(found), 32'h1);
        check_val("ind_level_a", 32'(level_a), 32'h5050);
        check_val("ind_level_b", 32'(level_b), 32'h7070);

        // Randomised requests, bypass toggles and occasional resets.
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
            end
            led_req = 4'($urandom_range(0, 15));
            bypass  = ($urandom_range(0, 4) == 0);
            repeat ($urandom_range(1, 80)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
